// File: rtl/saida_display.sv
// saida_display: captures the display bus on OUT, converts it to BCD by double-dabble and drives 8 active-low 7-segment digits
// Ports:
//   clock      system clock shared with the core
//   reset_n    asynchronous active-low reset
//   valor      28-bit display bus from the core
//   OpOut      OUT strobe, one high cycle per OUT instruction
//   segmentos  8 digits x 7 segments (gfedcba, active-low), digit 0 on bits 6:0
//   ocupado    conversion or result load in progress
//   pronto     one-cycle pulse when segmentos updates
//   estouro    value exceeds 99_999_999 (only the low 8 digits are shown)
module saida_display #(
    parameter bit SUPRIME_ZEROS = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [27:0] valor,
    input  logic        OpOut,
    output logic [55:0] segmentos,
    output logic        ocupado,
    output logic        pronto,
    output logic        estouro
);
    typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} estado_t;
    estado_t estado, estado_nxt;
    logic [27:0] bin, pend_val, carga;
    logic        pend_v, carrega;
    logic [35:0] bcd, bcd_adj;
    logic [4:0]  cnt;
    logic [31:0] disp;
    logic [7:0]  blank;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        estado_nxt = estado;
        carrega    = 1'b0;
        carga      = valor;
        case (estado)
            OCIOSO: begin
                carrega    = OpOut;
                estado_nxt = OpOut ? CONVERTE : OCIOSO;
            end
            CONVERTE: estado_nxt = (cnt == 5'd27) ? ATUALIZA : CONVERTE;
            default: begin
                // a fresh OUT in the update cycle supersedes the pending slot
                carrega    = OpOut || pend_v;
                carga      = OpOut ? valor : pend_val;
                estado_nxt = carrega ? CONVERTE : OCIOSO;
            end
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 9; i++)
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            pend_val <= '0;
            pend_v   <= 1'b0;
            disp     <= '0;
            estouro  <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            estado <= estado_nxt;
            pronto <= (estado == ATUALIZA);
            if (carrega) begin
                bin <= carga;
                bcd <= '0;
                cnt <= '0;
            end else if (estado == CONVERTE) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                cnt        <= cnt + 5'd1;
            end
            if (estado == ATUALIZA)
                pend_v <= 1'b0;
            else if (estado == CONVERTE && OpOut) begin
                pend_v   <= 1'b1;
                pend_val <= valor;
            end
            if (estado == ATUALIZA) begin
                disp    <= bcd[31:0];
                estouro <= |bcd[35:32];
            end
        end
    end

    assign ocupado = (estado != OCIOSO);

    for (genvar d = 0; d < 8; d++) begin : g_dig
        // blank when this digit and everything above it is zero
        assign blank[d] = SUPRIME_ZEROS && !estouro && d != 0 && (disp >> (4 * d)) == 32'd0;
        assign segmentos[7*d +: 7] = blank[d] ? 7'b1111111 : dec(disp[4*d +: 4]);
    end
endmodule
